// File: rtl/wb_stage_pkg.sv
// Shared constants and bus types for the MEM/WB write-back slice.
// Optional feature macro used by this slice: WB_HILO_BYPASS_EN.
package wb_stage_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;

  typedef logic [4:0]  RegAddrBus;
  typedef logic [31:0] RegBus;

  localparam RegBus ZeroWord = '0;

  // Bit positions within the six-bit pipeline stall vector
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair, written on a committing WB HI/LO write.
// Defining WB_HILO_BYPASS_EN makes the read ports write-through.
module hilo_reg
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit,
  input  logic              whilo,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              we;

  assign we = commit & whilo;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (we == WriteEnable) begin
      hi_q <= hi;
      lo_q <= lo;
    end
  end

`ifdef WB_HILO_BYPASS_EN
  // Forward the in-flight value even while WB is held; it will be written once the hold clears
  assign hi_o = whilo ? hi : hi_q;
  assign lo_o = whilo ? lo : lo_q;
`else
  assign hi_o = hi_q;
  assign lo_o = lo_q;
`endif

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, HI/LO ownership and retired-instruction counter.
// Build option: WB_HILO_BYPASS_EN (write-through HI/LO read ports in hilo_reg).
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_whilo,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [31:0]       instret
);

  logic  valid_q;
  logic  commit;
  RegBus instret_q;

  // The WB occupant retires on any non-reset edge where WB is not held
  assign commit = (rst != RstEnable) && !stall[STALL_WB];

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      valid_q  <= 1'b0;
      wb_wd    <= '0;
      wb_wreg  <= 1'b0;
      wb_wdata <= '0;
      wb_whilo <= 1'b0;
      wb_hi    <= '0;
      wb_lo    <= '0;
    end else if (stall[STALL_MEM] && !stall[STALL_WB]) begin
      valid_q  <= 1'b0;
      wb_wd    <= '0;
      wb_wreg  <= 1'b0;
      wb_wdata <= '0;
      wb_whilo <= 1'b0;
      wb_hi    <= '0;
      wb_lo    <= '0;
    end else if (!(stall[STALL_MEM] && stall[STALL_WB])) begin
      valid_q  <= mem_valid;
      wb_wd    <= mem_wd;
      wb_wreg  <= mem_wreg;
      wb_wdata <= mem_wdata;
      wb_whilo <= mem_whilo;
      wb_hi    <= mem_hi;
      wb_lo    <= mem_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      instret_q <= ZeroWord;
    end else if (commit && valid_q) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;

  hilo_reg #(
    .DATA_W(DATA_W)
  ) u_hilo (
    .clk    (clk),
    .rst    (rst),
    .commit (commit),
    .whilo  (wb_whilo),
    .hi     (wb_hi),
    .lo     (wb_lo),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// against a behavioural model of the write-back stage (honours WB_HILO_BYPASS_EN).
module tb_wb_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    stall;
  logic          mem_valid;
  logic [AW-1:0] mem_wd;
  logic          mem_wreg;
  logic [DW-1:0] mem_wdata;
  logic          mem_whilo;
  logic [DW-1:0] mem_hi;
  logic [DW-1:0] mem_lo;
  logic [AW-1:0] wb_wd;
  logic          wb_wreg;
  logic [DW-1:0] wb_wdata;
  logic          wb_whilo;
  logic [DW-1:0] wb_hi;
  logic [DW-1:0] wb_lo;
  logic [DW-1:0] hi_o;
  logic [DW-1:0] lo_o;
  logic [31:0]   instret;

  always #5 clk = ~clk;

  wb_stage #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .mem_valid (mem_valid),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_whilo (mem_whilo),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
    .wb_wd     (wb_wd),
    .wb_wreg   (wb_wreg),
    .wb_wdata  (wb_wdata),
    .wb_whilo  (wb_whilo),
    .wb_hi     (wb_hi),
    .wb_lo     (wb_lo),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .instret   (instret)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: the instruction sitting in WB, the architectural HI/LO, and the retire count
  typedef struct {
    logic          valid;
    logic [AW-1:0] wd;
    logic          wreg;
    logic [DW-1:0] wdata;
    logic          whilo;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
  } instr_t;

  instr_t        m_wb;
  logic [DW-1:0] m_hi_reg;
  logic [DW-1:0] m_lo_reg;
  logic [31:0]   m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] eh, el;
`ifdef WB_HILO_BYPASS_EN
    eh = m_wb.whilo ? m_wb.hi : m_hi_reg;
    el = m_wb.whilo ? m_wb.lo : m_lo_reg;
`else
    eh = m_hi_reg;
    el = m_lo_reg;
`endif
    check({tag, ".wb_wd"},    32'(wb_wd),    32'(m_wb.wd));
    check({tag, ".wb_wreg"},  32'(wb_wreg),  32'(m_wb.wreg));
    check({tag, ".wb_wdata"}, wb_wdata,      m_wb.wdata);
    check({tag, ".wb_whilo"}, 32'(wb_whilo), 32'(m_wb.whilo));
    check({tag, ".wb_hi"},    wb_hi,         m_wb.hi);
    check({tag, ".wb_lo"},    wb_lo,         m_wb.lo);
    check({tag, ".hi_o"},     hi_o,          eh);
    check({tag, ".lo_o"},     lo_o,          el);
    check({tag, ".instret"},  instret,       m_cnt);
  endtask

  // Apply one clock edge to the model (from the inputs as they stand), then compare
  task automatic tick(input string tag);
    instr_t empty;
    instr_t incoming;
    empty    = '{valid: 1'b0, wd: '0, wreg: 1'b0, wdata: '0, whilo: 1'b0, hi: '0, lo: '0};
    incoming = '{valid: mem_valid, wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata,
                 whilo: mem_whilo, hi: mem_hi, lo: mem_lo};
    if (rst) begin
      m_wb     = empty;
      m_hi_reg = '0;
      m_lo_reg = '0;
      m_cnt    = '0;
    end else begin
      if (!stall[5]) begin
        if (m_wb.whilo) begin
          m_hi_reg = m_wb.hi;
          m_lo_reg = m_wb.lo;
        end
        if (m_wb.valid) m_cnt = m_cnt + 1;
      end
      if (stall[4] && !stall[5])     m_wb = empty;
      else if (!(stall[4] && stall[5])) m_wb = incoming;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic v, input logic [AW-1:0] wd, input logic wr,
                        input logic [DW-1:0] wdat, input logic whl,
                        input logic [DW-1:0] h, input logic [DW-1:0] l);
    mem_valid = v;
    mem_wd    = wd;
    mem_wreg  = wr;
    mem_wdata = wdat;
    mem_whilo = whl;
    mem_hi    = h;
    mem_lo    = l;
  endtask

  task automatic set_rand_in();
    set_in(1'($urandom), AW'($urandom_range(0, 31)), 1'($urandom), $urandom,
           1'($urandom), $urandom, $urandom);
  endtask

  logic [31:0] cnt0;
  logic [DW-1:0] hi0;

  initial begin
    // Reset with busy inputs
    rst   = 1'b1;
    stall = 6'b000000;
    set_in(1'b1, 5'd9, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'hFFFF_0000, 32'h0000_FFFF);
    tick("reset1");
    tick("reset2");
    check("reset.instret", instret, 32'd0);
    check("reset.hi_o", hi_o, 32'd0);
    rst = 1'b0;

    // Plain flow
    set_in(1'b1, 5'd3, 1'b1, 32'h1234_5678, 1'b0, '0, '0);
    tick("flow.cap");
    check("flow.wb_wreg", 32'(wb_wreg), 32'd1);
    check("flow.wb_wd", 32'(wb_wd), 32'd3);
    check("flow.wb_wdata", wb_wdata, 32'h1234_5678);
    set_in(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    tick("flow.ret");
    check("flow.instret", instret, 32'd1);

    // HI/LO write
    set_in(1'b1, 5'd0, 1'b0, '0, 1'b1, 32'hAAAA_0001, 32'h5555_0002);
    tick("hilo.wb");
`ifdef WB_HILO_BYPASS_EN
    check("hilo.bypass_hi", hi_o, 32'hAAAA_0001);
    check("hilo.bypass_lo", lo_o, 32'h5555_0002);
`else
    check("hilo.early_hi", hi_o, 32'd0);
`endif
    set_in(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    tick("hilo.after");
    check("hilo.hi", hi_o, 32'hAAAA_0001);
    check("hilo.lo", lo_o, 32'h5555_0002);

    // Bubble: valid HI/LO writer at the inputs must be squashed
    cnt0  = instret;
    stall = 6'b010000;
    set_in(1'b1, 5'd7, 1'b1, 32'h7777_7777, 1'b1, 32'h1111_1111, 32'h2222_2222);
    tick("bubble");
    tick("bubble2");
    check("bubble.wb_wreg", 32'(wb_wreg), 32'd0);
    check("bubble.wb_whilo", 32'(wb_whilo), 32'd0);
    check("bubble.hi", hi_o, 32'hAAAA_0001);
    check("bubble.instret", instret, cnt0);

    // Hold: WB holds a valid whilo instruction for 3 cycles
    stall = 6'b000000;
    set_in(1'b1, 5'd12, 1'b1, 32'hCAFE_0000, 1'b1, 32'hB0B0_B0B0, 32'hC1C1_C1C1);
    tick("hold.load");
    cnt0  = instret;
    stall = 6'b110000;
    set_in(1'b1, 5'd1, 1'b1, 32'h0BAD_0BAD, 1'b1, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick("hold");
      check("hold.wb_wdata", wb_wdata, 32'hCAFE_0000);
      check("hold.instret", instret, cnt0);
    end
`ifndef WB_HILO_BYPASS_EN
    check("hold.hi_unwritten", hi_o, 32'hAAAA_0001);
`endif
    stall = 6'b000000;
    set_in(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    tick("hold.release");
    check("hold.instret_once", instret, cnt0 + 32'd1);
    check("hold.hi", hi_o, 32'hB0B0_B0B0);
    tick("hold.after");
    check("hold.instret_stable", instret, cnt0 + 32'd1);

    // Wrap: park a valid instruction in WB, preload the counter, then commit
    set_in(1'b1, 5'd4, 1'b1, 32'h4444_4444, 1'b0, '0, '0);
    tick("wrap.load");
    stall = 6'b110000;
    tick("wrap.hold");
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    m_cnt = 32'hFFFF_FFFF;
    check("wrap.preload", instret, 32'hFFFF_FFFF);
    stall = 6'b000000;
    set_in(1'b1, 5'd6, 1'b1, 32'h6666_6666, 1'b1, 32'hDDDD_0000, 32'hEEEE_0000);
    tick("wrap.commit");
    check("wrap.instret", instret, 32'd0);

    // Reset during a hold drops the pending HI/LO write
    stall = 6'b110000;
    tick("rsthold.hold");
    rst = 1'b1;
    tick("rsthold.rst");
    check("rsthold.hi", hi_o, 32'd0);
    check("rsthold.instret", instret, 32'd0);
    rst   = 1'b0;
    stall = 6'b000000;
    set_in(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    tick("rsthold.after");
    check("rsthold.hi_after", hi_o, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0:       stall = 6'b010000;
        1:       stall = 6'b110000;
        2:       stall = 6'b100000;
        3:       stall = 6'($urandom);
        default: stall = 6'b000000;
      endcase
      rst = ($urandom_range(0, 49) == 0);
      set_rand_in();
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
